// File: rtl/jt51_timer_pkg.sv
// Shared definitions for the JT51 timer controller slice.
// Register addresses of the timer block and bit positions inside the
// timer-control register 0x14.
package jt51_timer_pkg;

    localparam logic [7:0] REG_CLKA1 = 8'h10;  // timer A value bits [9:2]
    localparam logic [7:0] REG_CLKA2 = 8'h11;  // timer A value bits [1:0]
    localparam logic [7:0] REG_CLKB  = 8'h12;  // timer B value
    localparam logic [7:0] REG_TCTRL = 8'h14;  // load / irq enable / flag reset / csm

    localparam int TCTRL_LOAD_A  = 0;
    localparam int TCTRL_LOAD_B  = 1;
    localparam int TCTRL_IRQEN_A = 2;
    localparam int TCTRL_IRQEN_B = 3;
    localparam int TCTRL_CLR_A   = 4;
    localparam int TCTRL_CLR_B   = 5;
    localparam int TCTRL_CSM     = 7;

endpackage

// File: rtl/jt51_timer_ctrl_if.sv
// Bus between the CPU / jt51_timers side (master) and jt51_timer_ctrl (slave).
//   cen, wr, a0, din              : clock enable and CPU write port
//   flag_A, flag_B, overflow_A    : timer status from jt51_timers
//   value_A/B, load_*, enable_*,
//   clr_flag_*, zero              : timer configuration and sample tick
//   csm_keyon, busy, status       : CSM key-on, write-busy and status byte
interface jt51_timer_ctrl_if;
    import jt51_timer_pkg::*;

    logic       cen;
    logic       wr;
    logic       a0;
    logic [7:0] din;
    logic       flag_A;
    logic       flag_B;
    logic       overflow_A;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A;
    logic       load_B;
    logic       enable_irq_A;
    logic       enable_irq_B;
    logic       clr_flag_A;
    logic       clr_flag_B;
    logic       zero;
    logic       csm_keyon;
    logic       busy;
    logic [7:0] status;

    modport slave (
        input  cen, wr, a0, din, flag_A, flag_B, overflow_A,
        output value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B,
               clr_flag_A, clr_flag_B, zero, csm_keyon, busy, status
    );

    modport master (
        output cen, wr, a0, din, flag_A, flag_B, overflow_A,
        input  value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B,
               clr_flag_A, clr_flag_B, zero, csm_keyon, busy, status
    );

endinterface

// File: rtl/jt51_timer_ctrl_regs.sv
// jt51_timer_regs: address latch, data decode and timer register storage.
//   clk, rst        : clock, async active-high reset
//   wr_i, a0_i, din_i : CPU write port (a0=0 address, a0=1 data)
//   value_a_o/b_o   : timer start values
//   load_*_o, irqen_*_o, csm_o : stored 0x14 fields
//   clr_*_o         : one-clk flag-reset pulses (never stored)
module jt51_timer_regs
    import jt51_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic       a0_i,
    input  logic [7:0] din_i,
    output logic [9:0] value_a_o,
    output logic [7:0] value_b_o,
    output logic       load_a_o,
    output logic       load_b_o,
    output logic       irqen_a_o,
    output logic       irqen_b_o,
    output logic       csm_o,
    output logic       clr_a_o,
    output logic       clr_b_o
);

    logic [7:0] addr_q, addr_d;
    logic [9:0] val_a_q, val_a_d;
    logic [7:0] val_b_q, val_b_d;
    logic [4:0] ctrl_q, ctrl_d;   // {csm, irqen_b, irqen_a, load_b, load_a}
    logic [1:0] clr_q, clr_d;     // {clr_b, clr_a}

    always_comb begin
        addr_d  = addr_q;
        val_a_d = val_a_q;
        val_b_d = val_b_q;
        ctrl_d  = ctrl_q;
        clr_d   = 2'b00;
        if (wr_i && !a0_i) addr_d = din_i;
        if (wr_i && a0_i) begin
            case (addr_q)
                REG_CLKA1: val_a_d[9:2] = din_i;
                REG_CLKA2: val_a_d[1:0] = din_i[1:0];
                REG_CLKB:  val_b_d      = din_i;
                REG_TCTRL: begin
                    ctrl_d = {din_i[TCTRL_CSM], din_i[TCTRL_IRQEN_B], din_i[TCTRL_IRQEN_A],
                              din_i[TCTRL_LOAD_B], din_i[TCTRL_LOAD_A]};
                    clr_d  = {din_i[TCTRL_CLR_B], din_i[TCTRL_CLR_A]};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            val_a_q <= '0;
            val_b_q <= '0;
            ctrl_q  <= '0;
            clr_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            val_a_q <= val_a_d;
            val_b_q <= val_b_d;
            ctrl_q  <= ctrl_d;
            clr_q   <= clr_d;
        end
    end

    assign value_a_o = val_a_q;
    assign value_b_o = val_b_q;
    assign load_a_o  = ctrl_q[0];
    assign load_b_o  = ctrl_q[1];
    assign irqen_a_o = ctrl_q[2];
    assign irqen_b_o = ctrl_q[3];
    assign csm_o     = ctrl_q[4];
    assign clr_a_o   = clr_q[0];
    assign clr_b_o   = clr_q[1];

endmodule

// File: rtl/jt51_timer_ctrl.sv
// jt51_timer_ctrl: CPU-facing controller sequencing the jt51_timers pair.
//   clk, rst : clock, async active-high reset
//   bus      : jt51_timer_ctrl_if.slave (write port, timer status in;
//              timer config, zero tick, csm_keyon, busy, status out)
// Holds the slot counter (zero tick), busy down-counter and CSM pulse timer;
// register decode lives in jt51_timer_regs.
module jt51_timer_ctrl
    import jt51_timer_pkg::*;
#(
    parameter int SLOTS      = 32,
    parameter int BUSY_TICKS = 32,
    parameter int CSM_TICKS  = 32
) (
    input  logic                clk,
    input  logic                rst,
    jt51_timer_ctrl_if.slave    bus
);

    localparam int SW = $clog2(SLOTS);
    localparam int BW = $clog2(BUSY_TICKS + 1);
    localparam int CW = $clog2(CSM_TICKS + 1);

    logic          csm;
    logic          data_wr;
    logic          csm_ev;
    logic [SW-1:0] slot_q, slot_d;
    logic [BW-1:0] busy_q, busy_d;
    logic [CW-1:0] csm_q,  csm_d;

    jt51_timer_regs u_regs (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (bus.wr),
        .a0_i      (bus.a0),
        .din_i     (bus.din),
        .value_a_o (bus.value_A),
        .value_b_o (bus.value_B),
        .load_a_o  (bus.load_A),
        .load_b_o  (bus.load_B),
        .irqen_a_o (bus.enable_irq_A),
        .irqen_b_o (bus.enable_irq_B),
        .csm_o     (csm),
        .clr_a_o   (bus.clr_flag_A),
        .clr_b_o   (bus.clr_flag_B)
    );

    assign data_wr = bus.wr & bus.a0;
    // csm is the registered bit, so a same-clk 0x14 write cannot affect this event
    assign csm_ev  = bus.cen & bus.zero & bus.overflow_A & csm;

    always_comb begin
        slot_d = slot_q;
        busy_d = busy_q;
        csm_d  = csm_q;
        if (bus.cen) slot_d = (slot_q == SW'(SLOTS - 1)) ? '0 : slot_q + 1'b1;
        // A reload wins over the decrement of the same cen tick, so the
        // count covers exactly N cen ticks after the load.
        if (data_wr)                     busy_d = BW'(BUSY_TICKS);
        else if (bus.cen && busy_q != 0) busy_d = busy_q - 1'b1;
        if (csm_ev)                      csm_d  = CW'(CSM_TICKS);
        else if (bus.cen && csm_q != 0)  csm_d  = csm_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            busy_q <= '0;
            csm_q  <= '0;
        end else begin
            slot_q <= slot_d;
            busy_q <= busy_d;
            csm_q  <= csm_d;
        end
    end

    assign bus.zero      = (slot_q == '0);
    assign bus.busy      = (busy_q != '0);
    assign bus.csm_keyon = (csm_q != '0);
    assign bus.status    = {bus.busy, 5'b0, bus.flag_B, bus.flag_A};

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
module tb_jt51_timer_ctrl;

    localparam int SLOTS = 32, BUSY_T = 32, CSM_T = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt51_timer_ctrl_if bus();

    jt51_timer_ctrl #(.SLOTS(SLOTS), .BUSY_TICKS(BUSY_T), .CSM_TICKS(CSM_T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass = 0, n_total = 0;

    // Reference model: tick counts since reset, timestamps of last write/event.
    logic [7:0]  m_addr, m_valB;
    logic [9:0]  m_valA;
    logic        m_loadA, m_loadB, m_eiA, m_eiB, m_csm, m_clrA, m_clrB;
    int unsigned m_ticks, m_tw, m_te;
    bit          m_wseen, m_eseen;

    task automatic model_reset();
        m_addr = 0; m_valA = 0; m_valB = 0;
        {m_loadA, m_loadB, m_eiA, m_eiB, m_csm, m_clrA, m_clrB} = '0;
        m_ticks = 0; m_tw = 0; m_te = 0; m_wseen = 0; m_eseen = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic bit exp_busy();
        return m_wseen && (m_ticks - m_tw) < BUSY_T;
    endfunction

    function automatic bit exp_keyon();
        return m_eseen && (m_ticks - m_te) < CSM_T;
    endfunction

    task automatic check_all();
        chk("value_A", 32'(bus.value_A), 32'(m_valA));
        chk("value_B", 32'(bus.value_B), 32'(m_valB));
        chk("ctrl", 32'({bus.enable_irq_B, bus.enable_irq_A, bus.load_B, bus.load_A}),
            32'({m_eiB, m_eiA, m_loadB, m_loadA}));
        chk("clr", 32'({bus.clr_flag_B, bus.clr_flag_A}), 32'({m_clrB, m_clrA}));
        chk("zero", 32'(bus.zero), 32'((m_ticks % SLOTS) == 0));
        chk("busy", 32'(bus.busy), 32'(exp_busy()));
        chk("csm_keyon", 32'(bus.csm_keyon), 32'(exp_keyon()));
        chk("status", 32'(bus.status),
            32'({exp_busy(), 5'b0, bus.flag_B, bus.flag_A}));
    endtask

    // Advance one clk: evaluate the spec rules on the pre-edge inputs.
    task automatic step();
        bit dw, ev;
        dw = bus.wr && bus.a0;
        ev = bus.cen && (m_ticks % SLOTS == 0) && bus.overflow_A && m_csm;
        if (bus.cen) m_ticks++;
        m_clrA = dw && m_addr == 8'h14 && bus.din[4];
        m_clrB = dw && m_addr == 8'h14 && bus.din[5];
        if (dw) begin
            case (m_addr)
                8'h10: m_valA[9:2] = bus.din;
                8'h11: m_valA[1:0] = bus.din[1:0];
                8'h12: m_valB = bus.din;
                8'h14: {m_csm, m_eiB, m_eiA, m_loadB, m_loadA} =
                       {bus.din[7], bus.din[3], bus.din[2], bus.din[1], bus.din[0]};
                default: ;
            endcase
            m_wseen = 1; m_tw = m_ticks;
        end
        if (bus.wr && !bus.a0) m_addr = bus.din;
        if (ev) begin m_eseen = 1; m_te = m_ticks; end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
        bus.wr = 1; bus.a0 = 0; bus.din = addr; step();
        bus.a0 = 1; bus.din = data; step();
        bus.wr = 0; bus.a0 = 0;
    endtask

    // Emulate timer A overflowing on every second sample tick.
    task automatic run_csm(input int n);
        for (int i = 0; i < n; i++) begin
            bus.overflow_A = (m_ticks % SLOTS == 0) && ((m_ticks / SLOTS) % 2 == 1);
            step();
        end
        bus.overflow_A = 0;
    endtask

    initial begin
        logic [7:0] atab [6];
        atab = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h13, 8'h00};
        bus.cen = 0; bus.wr = 0; bus.a0 = 0; bus.din = 0;
        bus.flag_A = 0; bus.flag_B = 0; bus.overflow_A = 0;
        model_reset();

        // reset state
        #23;
        check_all();
        chk("rst_status", 32'(bus.status), 32'h00);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // free-running sample tick
        bus.cen = 1;
        for (int i = 0; i < 70; i++) step();

        // timer A value, busy restart by second write
        cpu_write(8'h10, 8'hAB);
        for (int i = 0; i < 10; i++) step();
        cpu_write(8'h11, 8'h03);
        chk("value_A_2AF", 32'(bus.value_A), 32'h2AF);
        for (int i = 0; i < 40; i++) step();
        chk("busy_done", 32'(bus.busy), 32'h0);

        // control register with both flag resets
        cpu_write(8'h14, 8'h35);
        chk("load_A", 32'(bus.load_A), 32'h1);
        chk("clr_A_pulse", 32'({bus.clr_flag_B, bus.clr_flag_A}), 32'h3);
        step();
        chk("clr_gone", 32'({bus.clr_flag_B, bus.clr_flag_A}), 32'h0);

        // CSM enabled: key-on per overflow on alternate samples
        cpu_write(8'h10, 8'hFF);
        cpu_write(8'h11, 8'h02);
        cpu_write(8'h14, 8'h81);
        run_csm(5 * SLOTS);

        // CSM disabled: no key-on, flag_A reflected in status
        cpu_write(8'h14, 8'h01);
        bus.flag_A = 1;
        run_csm(4 * SLOTS);
        chk("keyon_off", 32'(bus.csm_keyon), 32'h0);
        chk("status_01", 32'(bus.status), 32'h01);
        bus.flag_A = 0;

        // randomized traffic with sparse cen
        for (int i = 0; i < 500; i++) begin
            bus.cen = ($urandom_range(0, 3) != 0);
            bus.wr = ($urandom_range(0, 5) == 0);
            bus.a0 = 1'($urandom_range(0, 1));
            bus.din = bus.a0 ? 8'($urandom) : atab[$urandom_range(0, 5)];
            bus.overflow_A = ($urandom_range(0, 3) == 0);
            bus.flag_A = 1'($urandom); bus.flag_B = 1'($urandom);
            step();
        end
        bus.wr = 0; bus.cen = 1; bus.overflow_A = 0;

        // reset while busy and mid CSM pulse
        cpu_write(8'h14, 8'h80);
        while (m_ticks % SLOTS != 0) step();
        bus.overflow_A = 1; step(); bus.overflow_A = 0;
        cpu_write(8'h12, 8'h5A);
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst_busy", 32'({bus.busy, bus.csm_keyon}), 32'h3);
        #2 rst = 1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_keyon", 32'(bus.csm_keyon), 32'h0);
        chk("arst_valA", 32'(bus.value_A), 32'h0);
        chk("arst_zero", 32'(bus.zero), 32'h1);
        model_reset();
        check_all();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jt51_timer_ctrl.md
Name: jt51_timer_ctrl

Overview:
CPU-facing controller that configures and sequences the JT51 timer pair (jt51_timers).
- Decodes writes to timer registers 0x10/0x11/0x12/0x14.
- Generates the per-sample zero tick from a slot counter.
- Drives load/clear/IRQ-enable controls.
- Produces the CSM key-on pulse on timer A overflow, the busy flag and the status byte.

Parameters:
SLOTS, 32, cen ticks per sample; zero asserted once per SLOTS ticks
BUSY_TICKS, 32, cen ticks busy stays high after a data write
CSM_TICKS, 32, cen ticks csm_keyon stays high per CSM event

Ports:
rst  in  1  asynchronous reset, active-high
clk  in  1  clock
cen  in  1  clock enable; all tick counting advances only when cen=1
wr  in  1  single-clk write strobe (sampled every clk, not gated by cen)
a0  in  1  0: address write, 1: data write
din  in  8  write data
flag_A  in  1  from jt51_timers
flag_B  in  1  from jt51_timers
overflow_A  in  1  from jt51_timers (combinational counter carry)
value_A  out  10  timer A start value {reg10[7:0], reg11[1:0]}
value_B  out  8  timer B start value (reg12)
load_A  out  1  level, reg14[0]
load_B  out  1  level, reg14[1]
enable_irq_A  out  1  level, reg14[2]
enable_irq_B  out  1  level, reg14[3]
clr_flag_A  out  1  one-clk pulse
clr_flag_B  out  1  one-clk pulse
zero  out  1  sample tick; high while slot counter = 0
csm_keyon  out  1  CSM key-on request to operator key logic
busy  out  1  write-busy flag
status  out  8  {busy, 5'b0, flag_B, flag_A}

Behaviour:
- Reset: all registers 0. value_A=0, value_B=0, all load/enable/clr outputs 0, csm bit 0, csm_keyon=0, busy=0, slot counter=0 (zero=1), address latch=0x00.
- Address write (wr & !a0): latch din into addr register. No other effect; busy unaffected.
- Data write (wr & a0): decode the latched addr.
  - 0x10: value_A[9:2] <= din
  - 0x11: value_A[1:0] <= din[1:0]
  - 0x12: value_B <= din
  - 0x14: csm <= din[7]; enable_irq_B <= din[3]; enable_irq_A <= din[2]; load_B <= din[1]; load_A <= din[0]
  - 0x14 with din[4]=1: clr_flag_A=1 for exactly the next clk; same for din[5] and clr_flag_B. Flag-reset bits are not stored.
  - Other addresses: ignored by this block, but still start busy.
  - Outputs update the clk after the strobe (1-clk latency).
- Write timing rules:
  - Writes are accepted while busy; a new data write restarts the busy count.
  - wr with cen=0 is still accepted.
- Slot counter:
  - 5-bit (width clog2(SLOTS)); increments on cen; wraps SLOTS-1 -> 0.
  - zero = (slot==0); no cen qualification. jt51_timers qualifies it with cen.
- Busy:
  - Set on the clk after a data write; down-counter loaded with BUSY_TICKS.
  - Decrements on cen; busy clears when the count reaches 0, i.e. BUSY_TICKS cen ticks after the write.
- CSM:
  - Event = cen & zero & overflow_A & csm.
  - On the event, csm_keyon rises the next clk and stays high for CSM_TICKS cen ticks.
  - A new event while active restarts the count.
  - Clearing csm mid-pulse does not truncate the pulse.
- Status: combinational from busy and the flag inputs.
- Reset mid-operation: asynchronous clear of everything; any pending clr pulse and csm pulse are dropped.
- Simultaneous events:
  - Data write to 0x14 and a CSM event on the same clk: the event uses the pre-write csm value.
  - clr pulse and timer overflow on the same clk: jt51_timers gives clr priority. This block does nothing special.

Decomposition:
- Shared package jt51_timer_pkg: constants REG_CLKA1=8'h10, REG_CLKA2=8'h11, REG_CLKB=8'h12, REG_TCTRL=8'h14; bit-index constants for the 0x14 fields.
- One natural sub-module, jt51_timer_regs: address latch, data decode, register storage and clr pulses.
- Slot counter, busy counter and CSM pulse stay in the top.

Test Plan:
- Reset, then count cen (cen every clk) -> zero high on ticks 0,32,64; status=8'h00; all outputs 0.
- Write addr 0x10 data 0xAB, addr 0x11 data 0x03 -> value_A=10'h2AF one clk after the second write. busy=1 for exactly 32 cen ticks after each data write; the second write restarts the count.
- Write 0x14 data 0x35 -> load_A=1, enable_irq_A=1, enable_irq_B=0, load_B=0. clr_flag_A and clr_flag_B each high for exactly one clk, then 0. Reading 0x14 bits back never shows the clr bits.
- With jt51_timers connected: value_A=10'h3FE, 0x14=0x81 -> overflow after 2 sample ticks. csm_keyon high for 32 cen ticks, then low. Repeats every 2 samples.
- Same setup with csm=0 -> csm_keyon stays 0 while flag_A still sets. Set flag_A externally -> status=8'h01.
- Assert rst mid-busy and mid-CSM pulse -> busy=0, csm_keyon=0, value_A=0 and zero=1 immediately (asynchronous), without waiting for a clk edge.
